// File: rtl/reg_writeback_pkg.sv
// ----------------------------------------------------------------------------
// reg_writeback_pkg
// Shared types for the register-file writeback block: register index and data
// widths, the {num, data} entry carried by the long-latency result FIFO, and a
// popcount helper used by the issue-side outstanding-write limit.
// ----------------------------------------------------------------------------
package reg_writeback_pkg;

    localparam int RegNumWidth = 5;
    localparam int DataWidth   = 32;
    localparam int NumRegs     = 1 << RegNumWidth;

    typedef logic [RegNumWidth-1:0] reg_num_t;
    typedef logic [DataWidth-1:0]   data_t;

    typedef struct packed {
        reg_num_t num;
        data_t    data;
    } wb_entry_t;

    localparam int EntryWidth = $bits(wb_entry_t);

    // Number of registers with a pending long-latency write.
    function automatic int popcount(input logic [NumRegs-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < NumRegs; i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// ----------------------------------------------------------------------------
// reg_writeback_if
// Bundles every non-clock signal of the writeback block.
//   master : execute/memory/decode side (drives wb, issue, lr, regNum0/1)
//   slave  : reg_writeback (drives issueReady, lrReady, hazard, regWrite*)
// ----------------------------------------------------------------------------
interface reg_writeback_if;
    import reg_writeback_pkg::*;

    // In-order pipeline writeback
    logic     wbValid;
    reg_num_t wbRegNum;
    data_t    wbData;
    // Long-latency issue handshake
    logic     issueValid;
    reg_num_t issueRegNum;
    logic     issueReady;
    // Long-latency result handshake
    logic     lrValid;
    reg_num_t lrRegNum;
    data_t    lrData;
    logic     lrReady;
    // Decode hazard query
    reg_num_t regNum0;
    reg_num_t regNum1;
    logic     hazard;
    // Register-file write port
    logic     regWriteEnable;
    reg_num_t regWriteNum;
    data_t    regWriteData;

    modport master (
        output wbValid, wbRegNum, wbData,
        output issueValid, issueRegNum, input issueReady,
        output lrValid, lrRegNum, lrData, input lrReady,
        output regNum0, regNum1, input hazard,
        input  regWriteEnable, regWriteNum, regWriteData
    );

    modport slave (
        input  wbValid, wbRegNum, wbData,
        input  issueValid, issueRegNum, output issueReady,
        input  lrValid, lrRegNum, lrData, output lrReady,
        input  regNum0, regNum1, output hazard,
        output regWriteEnable, regWriteNum, regWriteData
    );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO for long-latency results.
//   clk, reset       : clock, synchronous active-high reset (pointers only)
//   push_i, din_i    : write request and entry (ignored when full)
//   full_o           : no free entry
//   pop_i            : remove head (ignored when empty)
//   empty_o, head_o  : no entry / oldest entry (valid when !empty_o)
// ----------------------------------------------------------------------------
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries data only; validity is defined by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/reg_writeback.sv
// ----------------------------------------------------------------------------
// reg_writeback
// Merges in-order pipeline writebacks with out-of-order long-latency results
// onto the single register-file write port, and tracks registers that have a
// long-latency write outstanding.
//   clk, reset : clock, synchronous active-high reset
//   bus        : reg_writeback_if.slave (wb, issue, lr, hazard, regWrite*)
// Pipeline writebacks always win the port; queued results drain in bubbles.
// ----------------------------------------------------------------------------
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    reg_writeback_if.slave  bus
);

    logic [NumRegs-1:0] busy_q, busy_d;
    logic               wen_q, wen_d;
    reg_num_t           wnum_q, wnum_d;
    data_t              wdata_q, wdata_d;

    logic      fifo_full, fifo_empty;
    logic      push, pop, wb_take, issue_ready, issue_fire;
    wb_entry_t fifo_din, fifo_head;

    // Limiting outstanding writes to DEPTH guarantees every issued op has a
    // FIFO slot for its result.
    assign issue_ready = !busy_q[bus.issueRegNum] && (popcount(busy_q) < DEPTH);
    assign issue_fire  = bus.issueValid && issue_ready && (bus.issueRegNum != '0);

    // x0 results are accepted (lrReady) but never enqueued.
    assign push     = bus.lrValid && !fifo_full && (bus.lrRegNum != '0);
    assign fifo_din = '{num: bus.lrRegNum, data: bus.lrData};

    assign wb_take = bus.wbValid && (bus.wbRegNum != '0);
    assign pop     = !wb_take && !fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryWidth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (fifo_din),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_comb begin
        busy_d = busy_q;
        // Clear and set never target the same bit: issue is blocked while busy.
        if (pop)        busy_d[fifo_head.num]   = 1'b0;
        if (issue_fire) busy_d[bus.issueRegNum] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        wen_d   = 1'b0;
        wnum_d  = wnum_q;
        wdata_d = wdata_q;
        if (wb_take) begin
            wen_d   = 1'b1;
            wnum_d  = bus.wbRegNum;
            wdata_d = bus.wbData;
        end else if (pop) begin
            wen_d   = 1'b1;
            wnum_d  = fifo_head.num;
            wdata_d = fifo_head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            wen_q   <= 1'b0;
            wnum_q  <= '0;
            wdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            wen_q   <= wen_d;
            wnum_q  <= wnum_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.issueReady     = issue_ready;
    assign bus.lrReady        = !fifo_full;
    assign bus.hazard         = busy_q[bus.regNum0] | busy_q[bus.regNum1];
    assign bus.regWriteEnable = wen_q;
    assign bus.regWriteNum    = wnum_q;
    assign bus.regWriteData   = wdata_q;

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;
    import reg_writeback_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    wb_entry_t exp_q[$];

    reg_writeback_if bus();

    reg_writeback #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every register-file write must match the oldest expected one.
    always @(negedge clk) begin
        if (bus.regWriteEnable === 1'b1) begin
            wb_entry_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got x%0d=%h required no write", bus.regWriteNum, bus.regWriteData);
            end else begin
                e = exp_q.pop_front();
                if (bus.regWriteNum !== e.num || bus.regWriteData !== e.data) begin
                    errors++;
                    $display("FAIL sb_write got x%0d=%h required x%0d=%h", bus.regWriteNum, bus.regWriteData, e.num, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wbValid = 0; bus.wbRegNum = '0; bus.wbData = '0;
        bus.issueValid = 0; bus.issueRegNum = '0;
        bus.lrValid = 0; bus.lrRegNum = '0; bus.lrData = '0;
        bus.regNum0 = '0; bus.regNum1 = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        @(negedge clk);
        checks++;
        if (bus.regWriteEnable !== 1'b0 || bus.regWriteNum !== 5'd0 || bus.regWriteData !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b num=%0d data=%h required 0/0/0", bus.regWriteEnable, bus.regWriteNum, bus.regWriteData);
        end
        checks++;
        if (bus.issueReady !== 1'b1 || bus.lrReady !== 1'b1 || bus.hazard !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake got issueReady=%b lrReady=%b hazard=%b required 1/1/0", bus.issueReady, bus.lrReady, bus.hazard);
        end
        tick();
    endtask

    task automatic test_wb_single();
        bus.wbValid = 1; bus.wbRegNum = 5'd5; bus.wbData = 32'h1234;
        exp_q.push_back('{num: 5'd5, data: 32'h1234});
        tick();
        bus.wbValid = 0;
        @(negedge clk);
        checks++;
        if (bus.regWriteEnable !== 1'b1 || bus.regWriteNum !== 5'd5) begin
            errors++;
            $display("FAIL wb_latency got en=%b num=%0d required 1/5", bus.regWriteEnable, bus.regWriteNum);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.regWriteEnable !== 1'b0 || bus.regWriteNum !== 5'd5 || bus.regWriteData !== 32'h1234) begin
            errors++;
            $display("FAIL wb_hold got en=%b num=%0d data=%h required 0/5/1234", bus.regWriteEnable, bus.regWriteNum, bus.regWriteData);
        end
        tick();
    endtask

    task automatic test_long_latency();
        bus.issueValid = 1; bus.issueRegNum = 5'd7;
        @(negedge clk);
        checks++;
        if (bus.issueReady !== 1'b1) begin
            errors++;
            $display("FAIL ll_issue_ready got %b required 1", bus.issueReady);
        end
        tick();
        bus.issueValid = 0; bus.regNum0 = 5'd7; bus.regNum1 = 5'd2;
        @(negedge clk);
        checks++;
        if (bus.hazard !== 1'b1) begin
            errors++;
            $display("FAIL ll_hazard_set got %b required 1", bus.hazard);
        end
        bus.lrValid = 1; bus.lrRegNum = 5'd7; bus.lrData = 32'hDEAD;
        exp_q.push_back('{num: 5'd7, data: 32'hDEAD});
        tick();
        bus.lrValid = 0;
        @(negedge clk);
        checks++;
        if (bus.regWriteEnable !== 1'b0 || bus.hazard !== 1'b1) begin
            errors++;
            $display("FAIL ll_no_bypass got en=%b hazard=%b required 0/1", bus.regWriteEnable, bus.hazard);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.regWriteEnable !== 1'b1 || bus.regWriteNum !== 5'd7 || bus.hazard !== 1'b0) begin
            errors++;
            $display("FAIL ll_write got en=%b num=%0d hazard=%b required 1/7/0", bus.regWriteEnable, bus.regWriteNum, bus.hazard);
        end
        bus.regNum0 = '0; bus.regNum1 = '0;
        tick();
    endtask

    task automatic test_same_reg();
        bus.issueValid = 1; bus.issueRegNum = 5'd3;
        tick();
        @(negedge clk);
        checks++;
        if (bus.issueReady !== 1'b0) begin
            errors++;
            $display("FAIL dup_issue_blocked got %b required 0", bus.issueReady);
        end
        bus.issueValid = 0;
        bus.lrValid = 1; bus.lrRegNum = 5'd3; bus.lrData = 32'h0000_0033;
        exp_q.push_back('{num: 5'd3, data: 32'h0000_0033});
        tick();
        bus.lrValid = 0;
        @(negedge clk);
        checks++;
        if (bus.issueReady !== 1'b0) begin
            errors++;
            $display("FAIL dup_issue_queued got %b required 0", bus.issueReady);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.issueReady !== 1'b1) begin
            errors++;
            $display("FAIL dup_issue_released got %b required 1", bus.issueReady);
        end
        tick();
    endtask

    task automatic test_depth();
        bus.issueValid = 1; bus.issueRegNum = 5'd1;
        tick();
        bus.issueRegNum = 5'd2;
        tick();
        bus.issueValid = 0; bus.issueRegNum = 5'd4;
        @(negedge clk);
        checks++;
        if (bus.issueReady !== 1'b0) begin
            errors++;
            $display("FAIL depth_issue_limit got %b required 0", bus.issueReady);
        end
        for (int i = 0; i < 3; i++) begin
            bus.wbValid = 1; bus.wbRegNum = 5'(10 + i); bus.wbData = 32'hA000_0000 + 32'(i);
            exp_q.push_back('{num: 5'(10 + i), data: 32'hA000_0000 + 32'(i)});
            bus.lrValid = 1; bus.lrRegNum = 5'(i + 1); bus.lrData = 32'(111 * (i + 1));
            if (i == 2) begin
                bus.lrRegNum = 5'd4;
                @(negedge clk);
                checks++;
                if (bus.lrReady !== 1'b0) begin
                    errors++;
                    $display("FAIL depth_lr_full got %b required 0", bus.lrReady);
                end
            end
            tick();
        end
        bus.wbValid = 0; bus.lrValid = 0;
        exp_q.push_back('{num: 5'd1, data: 32'd111});
        exp_q.push_back('{num: 5'd2, data: 32'd222});
        @(negedge clk);
        checks++;
        if (bus.regWriteNum !== 5'd12) begin
            errors++;
            $display("FAIL depth_wb_last got x%0d required x12", bus.regWriteNum);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.regWriteEnable !== 1'b1 || bus.regWriteNum !== 5'd1) begin
            errors++;
            $display("FAIL depth_drain0 got en=%b x%0d required 1/x1", bus.regWriteEnable, bus.regWriteNum);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.regWriteEnable !== 1'b1 || bus.regWriteNum !== 5'd2) begin
            errors++;
            $display("FAIL depth_drain1 got en=%b x%0d required 1/x2", bus.regWriteEnable, bus.regWriteNum);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.regWriteEnable !== 1'b0 || bus.issueReady !== 1'b1 || bus.lrReady !== 1'b1) begin
            errors++;
            $display("FAIL depth_empty got en=%b issueReady=%b lrReady=%b required 0/1/1", bus.regWriteEnable, bus.issueReady, bus.lrReady);
        end
        bus.issueRegNum = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.issueValid = 1; bus.issueRegNum = 5'd1;
        tick();
        bus.issueValid = 0;
        bus.lrValid = 1; bus.lrRegNum = 5'd1; bus.lrData = 32'h1111;
        tick();
        bus.lrValid = 0;
        bus.wbValid = 1; bus.wbRegNum = 5'd9; bus.wbData = 32'h9999;
        exp_q.push_back('{num: 5'd9, data: 32'h9999});
        exp_q.push_back('{num: 5'd1, data: 32'h1111});
        tick();
        bus.wbValid = 0;
        @(negedge clk);
        checks++;
        if (bus.regWriteNum !== 5'd9) begin
            errors++;
            $display("FAIL b2b_wb_first got x%0d required x9", bus.regWriteNum);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.regWriteEnable !== 1'b1 || bus.regWriteNum !== 5'd1) begin
            errors++;
            $display("FAIL b2b_fifo_next got en=%b x%0d required 1/x1", bus.regWriteEnable, bus.regWriteNum);
        end
        tick();
        // x0 traffic on every path: nothing becomes busy, nothing is written.
        bus.issueValid = 1; bus.issueRegNum = 5'd0;
        bus.lrValid = 1; bus.lrRegNum = 5'd0; bus.lrData = 32'hBAD0;
        bus.wbValid = 1; bus.wbRegNum = 5'd0; bus.wbData = 32'hBAD1;
        @(negedge clk);
        checks++;
        if (bus.issueReady !== 1'b1 || bus.lrReady !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready got issueReady=%b lrReady=%b required 1/1", bus.issueReady, bus.lrReady);
        end
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.regWriteEnable !== 1'b0 || bus.hazard !== 1'b0) begin
                errors++;
                $display("FAIL x0_no_write got en=%b hazard=%b required 0/0", bus.regWriteEnable, bus.hazard);
            end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        bus.issueValid = 1; bus.issueRegNum = 5'd5;
        tick();
        bus.issueRegNum = 5'd6;
        tick();
        bus.issueValid = 0;
        for (int i = 0; i < 2; i++) begin
            bus.wbValid = 1; bus.wbRegNum = 5'(20 + i); bus.wbData = 32'hC000_0000 + 32'(i);
            exp_q.push_back('{num: 5'(20 + i), data: 32'hC000_0000 + 32'(i)});
            bus.lrValid = 1; bus.lrRegNum = 5'(5 + i); bus.lrData = 32'(55 + 11 * i);
            tick();
        end
        bus.lrValid = 0;
        bus.wbRegNum = 5'd22; bus.wbData = 32'hC000_0002;
        reset = 1;
        tick();
        reset = 0;
        idle();
        bus.regNum0 = 5'd5; bus.regNum1 = 5'd6; bus.issueRegNum = 5'd5;
        @(negedge clk);
        checks++;
        if (bus.regWriteEnable !== 1'b0 || bus.hazard !== 1'b0 || bus.lrReady !== 1'b1 || bus.issueReady !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_state got en=%b hazard=%b lrReady=%b issueReady=%b required 0/0/1/1",
                     bus.regWriteEnable, bus.hazard, bus.lrReady, bus.issueReady);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (bus.regWriteEnable !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_drain got en=%b x%0d required 0", bus.regWriteEnable, bus.regWriteNum);
            end
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_wb_single();
        test_long_latency();
        test_same_reg();
        test_depth();
        test_back_to_back();
        test_reset_midop();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
